fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the RV32IF pipeline, directly upstream of decode/control.
//  - Generates sequential PCs and issues requests to instruction memory.
//  - Buffers returned words in a small in-order FIFO.
//  - Presents one instruction per cycle, with opcode/func3/func7 broken out, to the control unit.
//  - Handles branch/jal/jalr redirects by flushing the buffer and discarding stale responses.
// PARAMETERS
//  RESET_VEC   32'h0000_0000  PC of the first fetch after reset
//  FIFO_DEPTH  2              instruction buffer entries; power of two, >=2; also max outstanding requests
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request this cycle
//  imem_addr       out  32  fetch address, word aligned
//  imem_rsp_valid  in   1   response word valid; one per accepted request, in order, latency >=1
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   taken branch/jal/jalr from execute
//  redirect_pc     in   32  new fetch PC; bits [1:0] ignored (forced 00)
//  inst_valid      out  1   inst_* holds a valid instruction
//  inst_ready      in   1   decode consumes the head this cycle (0 = stall)
//  inst_data       out  32  head instruction; 32'h0000_0013 (NOP) when empty
//  inst_pc         out  32  PC of head instruction
//  inst_opcode     out  7   inst_data[6:0]
//  inst_func3      out  3   inst_data[14:12]
//  inst_func7      out  7   inst_data[31:25]
// BEHAVIOUR
//  Reset values:
//  - pc_q = RESET_VEC.
//  - FIFO empty, outstanding = 0, discard_cnt = 0, state = S_BOOT.
//  - Outputs: inst_valid=0, inst_data=NOP, inst_pc=0, imem_req_valid=0, imem_addr=RESET_VEC.
//  States:
//  - S_BOOT -> S_RUN unconditionally after one cycle; no request is issued in S_BOOT.
//  - S_RUN: imem_req_valid = !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH).
//  - S_FLUSH: no requests; each response decrements discard_cnt and is dropped.
//    Exits to S_RUN in the cycle discard_cnt reaches 0.
//  Request and response handling:
//  - imem_addr = pc_q.
//  - On req handshake: pc_q += 4 (wraps modulo 2^32); outstanding += 1.
//  - On response: outstanding -= 1. In S_RUN, push {data, pc} onto the FIFO.
//  - The pushed pc comes from a parallel in-order PC queue (or is derived from head PC + 4*count).
//  - The credit rule guarantees a push never hits a full FIFO. Push and pop in the same cycle are both honoured.
//  Output:
//  - Pop when inst_valid && inst_ready.
//  - inst_* are driven from the FIFO head, with a latency of 1 cycle from imem_rsp_valid to inst_valid.
//  Redirect (highest priority):
//  - In the same cycle: FIFO cleared; any pop is ignored; a response arriving that cycle is dropped.
//  - pc_q <= {redirect_pc[31:2],2'b00}.
//  - discard_cnt <= outstanding - imem_rsp_valid.
//  - Next state: S_FLUSH if that count is nonzero, else S_RUN.
//  - A redirect during S_FLUSH or S_BOOT reloads the same way.
//  Invariants:
//  - outstanding never exceeds FIFO_DEPTH.
//  - A response with outstanding==0 is a protocol error; it is ignored.
//  Reset mid-operation:
//  - All state returns to reset values asynchronously.
//  - Responses for requests issued before reset are the memory's responsibility to squash.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds output ports perf_fetched[31:0] and perf_stall[31:0].
//  - perf_fetched: increments on every pop.
//  - perf_stall: increments each cycle with inst_valid && !inst_ready.
//  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
//  FETCH_PERF_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Shared header rv32_defs.vh holds:
//  - NOP encoding 32'h0000_0013, and RESET_VEC default.
//  - Opcode constants (OP_RTYPE 7'b0110011, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_FP 7'b1010011).
//  - State encodings S_BOOT/S_RUN/S_FLUSH.
//  Sub-module fetch_fifo:
//  - Parameterised DEPTH x 64-bit sync FIFO ({pc,data}) with push/pop/clear, count, and async active-low reset.
//  - fetch_unit holds only the FSM, PC, and credit/discard counters.
// TESTING
//  1. Reset, imem always ready, 1-cycle rsp
//     -> requests at 0x0,0x4,0x8...; first inst_valid at cycle 3 with inst_pc=0.
//  2. inst_ready=0 for 10 cycles
//     -> at most FIFO_DEPTH requests outstanding+buffered; no loss; resuming pops PCs in order, no gaps.
//  3. 2 requests outstanding, redirect_pc=0x100
//     -> both responses dropped; next inst_pc=0x100; inst_valid low until then.
//  4. Redirect in the same cycle as a response and a pop
//     -> response dropped, discard_cnt = outstanding-1, FIFO empty next cycle.
//  5. pc_q=0xFFFF_FFFC
//     -> next request addr 0x0000_0000; redirect_pc=0x203 -> fetch at 0x200.
//  6. FETCH_PERF_EN: 5 pops and 3 stall cycles
//     -> perf_fetched=5, perf_stall=3; build without the macro compiles with no perf ports.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// =====================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared RV32 encodings, fetch FSM states and buffer entry type.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam logic [31:0] NOP               = 32'h0000_0013;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FP     = 7'b1010011;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// =====================================================================
// Module   : fetch_fifo
// Brief    : DEPTH x 64-bit in-order instruction buffer with clear and count.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           wdata_i,
  input  logic                   pop_i,
  output fetch_entry_t           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            w_do_push;
  logic            w_do_pop;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign w_do_pop  = pop_i && (count_q != '0);
  assign w_do_push = push_i && ((count_q != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// =====================================================================
// Module   : fetch_unit
// Brief    : RV32IF fetch stage: PC sequencing, imem credit control,
//            redirect flush; FETCH_PERF_EN adds perf_fetched/perf_stall.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = RESET_VEC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [6:0]  inst_opcode,
  output logic [2:0]  inst_func3,
  output logic [6:0]  inst_func7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] outst_d;
  logic [CW-1:0] discard_q;

  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [CW-1:0] w_fifo_count;
  logic          w_credit;
  logic          w_req_fire;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redir_pc;
  logic          w_unused;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused   = &{1'b0, redirect_pc[1:0]};

  // Buffered plus in-flight words may never exceed the buffer size.
  assign w_credit       = ({1'b0, w_fifo_count} + {1'b0, outst_q}) < DEPTH_C;
  assign imem_req_valid = (state_q == S_RUN) && !redirect_valid && w_credit;
  assign imem_addr      = pc_q;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp   = imem_rsp_valid && (outst_q != '0);
  assign outst_d = outst_q + CW'(w_req_fire) - CW'(w_rsp);

  assign inst_valid = (w_fifo_count != '0);
  assign w_push     = w_rsp && (state_q == S_RUN) && !redirect_valid;
  assign w_pop      = inst_valid && inst_ready && !redirect_valid;

  // Requests are sequential between redirects, so the PC of the next kept
  // response is tracked with a single counter instead of a PC queue.
  assign w_push_entry = '{pc: rsp_pc_q, data: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (redirect_valid),
    .push_i  (w_push),
    .wdata_i (w_push_entry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .count_o (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_VEC;
      rsp_pc_q  <= RESET_VEC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      outst_q <= outst_d;
      if (redirect_valid) begin
        pc_q      <= w_redir_pc;
        rsp_pc_q  <= w_redir_pc;
        discard_q <= outst_d;
        state_q   <= (outst_d != '0) ? S_FLUSH : S_RUN;
      end else begin
        if (w_req_fire) pc_q     <= pc_q + 32'd4;
        if (w_push)     rsp_pc_q <= rsp_pc_q + 32'd4;
        case (state_q)
          S_BOOT: state_q <= S_RUN;
          S_RUN:  state_q <= S_RUN;
          S_FLUSH: begin
            if (discard_q == '0) begin
              state_q <= S_RUN;
            end else if (w_rsp) begin
              discard_q <= discard_q - CW'(1);
              if (discard_q == CW'(1)) state_q <= S_RUN;
            end
          end
          default: state_q <= S_BOOT;
        endcase
      end
    end
  end

  assign inst_data   = inst_valid ? w_head.data : NOP;
  assign inst_pc     = inst_valid ? w_head.pc : 32'h0;
  assign inst_opcode = inst_data[6:0];
  assign inst_func3  = inst_data[14:12];
  assign inst_func7  = inst_data[31:25];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (w_pop && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (inst_valid && !inst_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// =====================================================================
// Module   : tb_fetch_unit
// Brief    : Directed cycle tables and stall/perf sequences for fetch_unit.
// Revision : 1.0 - initial release
// =====================================================================
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [6:0]  inst_opcode;
  logic [2:0]  inst_func3;
  logic [6:0]  inst_func7;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_VEC  (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode),
    .inst_func3     (inst_func3),
    .inst_func7     (inst_func7)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  typedef struct {
    bit          rdy;
    bit          mrdy;
    bit          redir;
    logic [31:0] rpc;
    bit          ereq;
    logic [31:0] eaddr;
    bit          eiv;
    logic [31:0] eipc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  vec_t  tbl[$];
  pend_t pend[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    lat = 1;
  int    issued = 0;
  int    pops = 0;

  function automatic vec_t v(bit rdy, bit mrdy, bit redir, logic [31:0] rpc,
                             bit ereq, logic [31:0] eaddr, bit eiv, logic [31:0] eipc);
    vec_t r;
    r.rdy = rdy; r.mrdy = mrdy; r.redir = redir; r.rpc = rpc;
    r.ereq = ereq; r.eaddr = eaddr; r.eiv = eiv; r.eipc = eipc;
    return r;
  endfunction

  // Instruction word served for each address: R-type with address bits folded in.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[21:2], 5'b00000, OP_RTYPE};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Instruction memory: always returns one word per accepted request after lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{addr: imem_addr, due: cyc + lat});
        issued++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  task automatic step(vec_t r, int row, string tn);
    logic [31:0] ed;
    inst_ready     = r.rdy;
    imem_req_ready = r.mrdy;
    redirect_valid = r.redir;
    redirect_pc    = r.rpc;
    @(negedge clk);
    #1;
    ed = r.eiv ? mem_word(r.eipc) : NOP;
    chk($sformatf("%s[%0d].req_valid", tn, row), 32'(imem_req_valid), 32'(r.ereq));
    chk($sformatf("%s[%0d].addr", tn, row), imem_addr, r.eaddr);
    chk($sformatf("%s[%0d].inst_valid", tn, row), 32'(inst_valid), 32'(r.eiv));
    chk($sformatf("%s[%0d].inst_pc", tn, row), inst_pc, r.eiv ? r.eipc : 32'h0);
    chk($sformatf("%s[%0d].inst_data", tn, row), inst_data, ed);
    chk($sformatf("%s[%0d].opcode", tn, row), 32'(inst_opcode), 32'(ed[6:0]));
    chk($sformatf("%s[%0d].func3", tn, row), 32'(inst_func3), 32'(ed[14:12]));
    chk($sformatf("%s[%0d].func7", tn, row), 32'(inst_func7), 32'(ed[31:25]));
    if (inst_valid && inst_ready) pops++;
    @(posedge clk);
    #2;
  endtask

  task automatic run_table(string tn);
    foreach (tbl[i]) step(tbl[i], i, tn);
    tbl.delete();
  endtask

  task automatic do_reset(int new_lat);
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    lat    = new_lat;
    issued = 0;
    pops   = 0;
    rst_n  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          resume_pops;
    logic [31:0] exp_pc;

    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset.inst_valid", 32'(inst_valid), 32'd0);
    chk("reset.inst_data", inst_data, NOP);
    chk("reset.inst_pc", inst_pc, 32'h0);
    chk("reset.req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset.addr", imem_addr, 32'h0);
    @(posedge clk);
    #2;
    lat = 1; issued = 0; pops = 0;
    rst_n = 1'b1;

    // Sequential fetch, 1-cycle memory, decode always ready.
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h00, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h00, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h04, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h08, 1, 32'h04));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h0C, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h10, 1, 32'h08));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h10, 1, 32'h0C));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h14, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h18, 1, 32'h10));
    run_table("seq");

    // Decode stalls for 10 cycles, then resumes; PCs must continue from 0x14.
    for (int i = 0; i < 10; i++) begin
      inst_ready = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("stall[%0d].occupancy_ok", i), 32'((issued - pops) <= DEPTH), 32'd1);
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    #1;
    chk("stall_end.inst_valid", 32'(inst_valid), 32'd1);
    chk("stall_end.inst_pc", inst_pc, 32'h14);
    chk("stall_end.req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #2;
    exp_pc      = 32'h14;
    resume_pops = 0;
    inst_ready  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (inst_valid) begin
        chk($sformatf("resume[%0d].inst_pc", i), inst_pc, exp_pc);
        chk($sformatf("resume[%0d].inst_data", i), inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        resume_pops++;
      end
      @(posedge clk);
      #2;
    end
    chk("resume.pop_count_ge6", 32'(resume_pops >= 6), 32'd1);

    // Redirect with two requests in flight (3-cycle memory).
    do_reset(3);
    tbl.push_back(v(1, 1, 0, 0,        0, 32'h000, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        1, 32'h000, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        1, 32'h004, 0, 0));
    tbl.push_back(v(1, 1, 1, 32'h100,  0, 32'h008, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        0, 32'h100, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        0, 32'h100, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        1, 32'h100, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        1, 32'h104, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        0, 32'h108, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        0, 32'h108, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,        0, 32'h108, 1, 32'h100));
    run_table("redir_flush");

    // Redirect coinciding with a response and a pop.
    do_reset(1);
    tbl.push_back(v(1, 1, 0, 0,       0, 32'h00, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,       1, 32'h00, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,       1, 32'h04, 0, 0));
    tbl.push_back(v(1, 1, 1, 32'h40,  0, 32'h08, 1, 32'h00));
    tbl.push_back(v(1, 1, 0, 0,       1, 32'h40, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,       1, 32'h44, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,       0, 32'h48, 1, 32'h40));
    run_table("redir_same_cycle");

    // PC wrap, imem back-pressure, and low-bit masking of redirect_pc.
    do_reset(1);
    tbl.push_back(v(1, 1, 0, 0,            0, 32'h0000_0000, 0, 0));
    tbl.push_back(v(1, 1, 1, 32'hFFFF_FFFF, 0, 32'h0000_0000, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,            1, 32'h0000_0000, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,            0, 32'h0000_0004, 1, 32'hFFFF_FFFC));
    tbl.push_back(v(1, 1, 1, 32'h0000_0203, 0, 32'h0000_0004, 1, 32'h0000_0000));
    tbl.push_back(v(1, 1, 0, 0,            1, 32'h0000_0200, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,            1, 32'h0000_0204, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,            0, 32'h0000_0208, 1, 32'h0000_0200));
    run_table("wrap_align");

    // Fill the buffer while stalled, then drain: 3 stall cycles and 5 pops.
    do_reset(1);
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 32'h04, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h08, 1, 32'h04));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h0C, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h10, 1, 32'h08));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h10, 1, 32'h0C));
    tbl.push_back(v(1, 1, 0, 0, 1, 32'h14, 0, 0));
    tbl.push_back(v(1, 1, 0, 0, 0, 32'h18, 1, 32'h10));
    run_table("fill_drain");
`ifdef FETCH_PERF_EN
    @(negedge clk);
    #1;
    chk("perf.fetched", perf_fetched, 32'd5);
    chk("perf.stall", perf_stall, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
